siso_tx_scheduler: RTL and testbench
====================================

Name: siso_tx_scheduler

Overview:
- Shares one serial-out shift channel between NUM_REQ requesters.
- Each requester offers a WIDTH-bit parallel word with a valid/ready handshake.
- A round-robin arbiter grants one requester at a time. Its word is shifted out LSB-first on a single serial line, followed by a programmable idle gap.
- Sits in front of the serial shift datapath and sequences every frame onto it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, bits per frame word (≥2).
- GAP_CYCLES, 1, idle cycles inserted after each frame (0..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  requester i has a word pending.
- req_data  input  NUM_REQ*WIDTH  word of requester i in bits [i*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  one-hot; high for the requester whose word is accepted this cycle.
- so  output  1  serial data out, registered.
- so_valid  output  1  so carries a frame bit this cycle.
- grant_id  output  clog2(NUM_REQ)  index of the requester currently being shifted.
- busy  output  1  high in SHIFT or GAP.
- frame_done  output  1  one-cycle pulse coincident with the last frame bit on so.

Behaviour:
- Reset (reset=0, async), applied immediately:
  - state=IDLE; so=0, so_valid=0, frame_done=0, busy=0, grant_id=0, req_ready=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has top priority first.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - req_ready is combinational: the winner is the first i with req_valid[i]=1, searching from last+1 upward with wrap.
  - Only the winner's ready bit is high. No ready is asserted if no request is valid.
  - Accept on the rising edge where req_valid[w]&req_ready[w]:
    - load shreg ← word w; grant_id ← w; last ← w; bit counter ← 0; go to SHIFT.
- SHIFT:
  - Frame bits appear on so during the WIDTH cycles following the accept edge, word[0] first.
  - so_valid=1 throughout; shreg shifts right one bit per cycle.
  - frame_done=1 during the cycle word[WIDTH-1] is on so.
  - Next state after that cycle: GAP if GAP_CYCLES>0, else IDLE.
  - req_ready=0 for all requesters in SHIFT and GAP.
  - Requester valid/data changes during SHIFT have no effect (word already captured).
- GAP: so=0, so_valid=0 for exactly GAP_CYCLES cycles, then IDLE.
- Back-to-back throughput:
  - With GAP_CYCLES=0 and requests pending, the next accept happens in the IDLE cycle right after the last bit.
  - Minimum frame period is WIDTH+1+GAP_CYCLES cycles.
- grant_id holds its value until the next accept.
- busy=1 in SHIFT and GAP.
- Reset asserted mid-frame:
  - the frame is aborted and no frame_done is issued;
  - after release, the frame is not resumed and the requester must re-request.
- Requester dropping valid in IDLE before an accept edge: no transfer; arbitration re-evaluates every cycle.

Optional Feature:
- Macro: SISO_TX_PARITY_EN.
- Defined:
  - One even-parity bit (XOR of the WIDTH data bits) follows word[WIDTH-1], with so_valid=1.
  - The frame is WIDTH+1 bits long.
  - frame_done moves to the parity-bit cycle.
- Undefined: no parity bit, no parity logic, frame is WIDTH bits.

Decomposition:
- Package siso_tx_pkg holds:
  - state enum (IDLE, SHIFT, GAP);
  - function for the counter width, clog2(WIDTH+1);
  - localparam for the frame length, including the parity adjustment under the macro.
- Sub-module siso_rr_arbiter: combinational round-robin grant from req_valid and the last pointer, output one-hot plus index. It is instantiated once.

Test Plan:
- Single frame: reset, then req_valid[2]=1 with data 4'b1011.
  - req_ready[2] high for one cycle.
  - so = 1,1,0,1 on four consecutive cycles with so_valid=1.
  - grant_id=2; frame_done on the 4th bit; then one GAP cycle with so=0.
- Simultaneous: req_valid=4'b0011 after reset, data0=4'hA, data1=4'h5.
  - Requester 0 is served first (so=0,1,0,1), then requester 1 (1,0,1,0).
- Fairness: all four valid continuously.
  - Grant order is 0,1,2,3,0.
  - The frame period is exactly 6 cycles (WIDTH=4, GAP=1).
- Reset mid-frame: assert reset after 2 bits of 4'hF.
  - so and so_valid drop to 0 immediately; no frame_done.
  - After release, requester 0 is re-granted first.
- GAP_CYCLES=0 variant, two requesters valid: the second accept occurs 1 cycle after the first frame's last bit.
- SISO_TX_PARITY_EN defined, data 4'b0111:
  - so = 1,1,1,0 followed by parity bit 1;
  - frame_done on the parity cycle.

Source files
------------

// File: rtl/siso_tx_pkg.sv
// Shared state encoding and sizing helpers for the serial TX scheduler.
// SISO_TX_PARITY_EN appends one even-parity bit to every frame.
package siso_tx_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

`ifdef SISO_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Bit counter must index every bit of the longest frame.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int frame_len(input int width);
        return width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/siso_rr_arbiter.sv
// Combinational round-robin grant: first valid requester after 'last', with wrap.
module siso_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_idx,
    output logic               gnt_any
);

    always_comb begin
        logic [IDW-1:0] idx;
        idx     = '0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((int'(last) + k) % NUM_REQ);
            if (!gnt_any && req_valid[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/siso_tx_scheduler.sv
// Round-robin scheduler sharing one LSB-first serial line among NUM_REQ requesters.
// Define SISO_TX_PARITY_EN to append an even-parity bit after each word.
module siso_tx_scheduler
    import siso_tx_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       so,
    output logic                       so_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int FLEN = frame_len(WIDTH);
    localparam int CW   = cnt_width(WIDTH);

    state_t             state;
    logic [IDW-1:0]     last;
    logic [IDW-1:0]     gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_any;
    logic [WIDTH-1:0]   word_w;
    logic [FLEN-1:0]    frame_w;
    logic [FLEN-1:0]    shreg;
    logic [CW-1:0]      bit_cnt;
    logic [3:0]         gap_cnt;

    siso_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
        .req_valid (req_valid),
        .last      (last),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_any   (gnt_any)
    );

    // Ready is masked during reset so nothing looks accepted while held.
    assign req_ready = (reset && state == IDLE) ? gnt : '0;
    assign word_w    = req_data[gnt_idx*WIDTH +: WIDTH];

`ifdef SISO_TX_PARITY_EN
    assign frame_w = {^word_w, word_w};
`else
    assign frame_w = word_w;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last       <= IDW'(NUM_REQ - 1);
            grant_id   <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            so         <= 1'b0;
            so_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (gnt_any) begin
                    // Bit 0 goes straight onto so; shreg holds the remainder.
                    state    <= SHIFT;
                    grant_id <= gnt_idx;
                    last     <= gnt_idx;
                    shreg    <= frame_w >> 1;
                    bit_cnt  <= '0;
                    so       <= frame_w[0];
                    so_valid <= 1'b1;
                    busy     <= 1'b1;
                end
                SHIFT: if (bit_cnt == CW'(FLEN - 1)) begin
                    so         <= 1'b0;
                    so_valid   <= 1'b0;
                    frame_done <= 1'b0;
                    gap_cnt    <= '0;
                    if (GAP_CYCLES > 0) begin
                        state <= GAP;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end else begin
                    bit_cnt    <= bit_cnt + CW'(1);
                    so         <= shreg[0];
                    shreg      <= shreg >> 1;
                    frame_done <= (bit_cnt == CW'(FLEN - 2));
                end
                GAP: if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    gap_cnt <= gap_cnt + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_siso_tx_scheduler.sv
// Randomized bench for siso_tx_scheduler: two instances (gap 1 and gap 0) against a timeline model.
module tb_siso_tx_scheduler;

    localparam int NR = 4;
    localparam int W  = 4;
    localparam int NI = 2;
`ifdef SISO_TX_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [NR*W-1:0] req_data = '0;

    logic [NR-1:0] rdy_o [NI];
    logic          so_o  [NI];
    logic          sv_o  [NI];
    logic          bz_o  [NI];
    logic          fd_o  [NI];
    logic [1:0]    gid_o [NI];

    siso_tx_scheduler #(.NUM_REQ(NR), .WIDTH(W), .GAP_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy_o[0]), .so(so_o[0]), .so_valid(sv_o[0]), .grant_id(gid_o[0]),
        .busy(bz_o[0]), .frame_done(fd_o[0])
    );

    siso_tx_scheduler #(.NUM_REQ(NR), .WIDTH(W), .GAP_CYCLES(0)) u_dut_nogap (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy_o[1]), .so(so_o[1]), .so_valid(sv_o[1]), .grant_id(gid_o[1]),
        .busy(bz_o[1]), .frame_done(fd_o[1])
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: m_t = 0 idle, 1..FL frame bit m_t-1 on so, FL+1..FL+gap idle gap.
    int            m_t    [NI];
    int            m_last [NI];
    int            m_gid  [NI];
    logic [FL-1:0] m_bits [NI];

    int acc0_cyc[$];
    int acc0_id[$];
    int acc1_cyc[$];
    int fd1_cyc[$];
    int frames[$];
    logic [FL-1:0] obs = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic logic [FL-1:0] exp_frame(input logic [W-1:0] word);
`ifdef SISO_TX_PARITY_EN
        return {^word, word};
`else
        return word;
`endif
    endfunction

    function automatic int winner(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++)
            if (v[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_t[i]    = 0;
            m_last[i] = NR - 1;
            m_gid[i]  = 0;
            m_bits[i] = '0;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < NI; i++) begin
            int            w;
            logic [NR-1:0] rdy;
            logic          sv;
            w   = winner(req_valid, m_last[i]);
            rdy = '0;
            if (reset && m_t[i] == 0 && w >= 0) rdy[w] = 1'b1;
            sv = (m_t[i] >= 1 && m_t[i] <= FL);
            chk($sformatf("req_ready%0d", i), rdy_o[i], rdy);
            chk($sformatf("so_valid%0d", i), sv_o[i], sv);
            chk($sformatf("so%0d", i), so_o[i], sv ? m_bits[i][m_t[i]-1] : 1'b0);
            chk($sformatf("frame_done%0d", i), fd_o[i], m_t[i] == FL);
            chk($sformatf("busy%0d", i), bz_o[i], m_t[i] != 0);
            chk($sformatf("grant_id%0d", i), gid_o[i], m_gid[i]);
        end
        // Observed-event logs used by the directed ordering/timing checks.
        if (rdy_o[0] != '0) begin
            acc0_cyc.push_back(cyc);
            for (int r = 0; r < NR; r++) if (rdy_o[0][r]) acc0_id.push_back(r);
        end
        if (sv_o[0]) obs = {so_o[0], obs[FL-1:1]};
        if (fd_o[0]) frames.push_back(int'(obs));
        if (rdy_o[1] != '0) acc1_cyc.push_back(cyc);
        if (fd_o[1]) fd1_cyc.push_back(cyc);
    endtask

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            if (m_t[i] == 0) begin
                int w;
                w = winner(req_valid, m_last[i]);
                if (w >= 0) begin
                    m_bits[i] = exp_frame(req_data[w*W +: W]);
                    m_t[i]    = 1;
                    m_gid[i]  = w;
                    m_last[i] = w;
                end
            end else begin
                m_t[i] = (m_t[i] >= FL + gap_of(i)) ? 0 : m_t[i] + 1;
            end
        end
    endtask

    // Entered and left at a falling edge; inputs are already driven.
    task automatic cycle();
        #1 check_outputs();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    task automatic wait_accepts(input int n, input int budget);
        int k;
        k = 0;
        while (acc0_id.size() < n && k < budget) begin
            cycle();
            k++;
        end
        chk("accept_timeout", acc0_id.size() >= n, 1'b1);
    endtask

    initial begin
        int n0, n1, nf, nd;
        model_reset();
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b1;

        // Single frame from requester 2
        nf = frames.size();
        n0 = acc0_id.size();
        req_valid = 4'b0100;
        req_data  = '0;
        req_data[2*W +: W] = 4'b1011;
        cycle();
        req_valid = '0;
        repeat (8) cycle();
        chk("single_grant", qget(acc0_id, n0), 2);
        chk("single_frame", qget(frames, nf), exp_frame(4'b1011));

        // Two simultaneous requesters: 0 then 1
        do_reset();
        n0 = acc0_id.size(); nf = frames.size();
        n1 = acc1_cyc.size(); nd = fd1_cyc.size();
        req_valid = 4'b0011;
        req_data  = '0;
        req_data[0 +: W] = 4'hA;
        req_data[W +: W] = 4'h5;
        wait_accepts(n0 + 2, 40);
        req_valid = '0;
        repeat (10) cycle();
        chk("simul_first", qget(acc0_id, n0), 0);
        chk("simul_second", qget(acc0_id, n0 + 1), 1);
        chk("simul_frame0", qget(frames, nf), exp_frame(4'hA));
        chk("simul_frame1", qget(frames, nf + 1), exp_frame(4'h5));
        chk("nogap_b2b", qget(acc1_cyc, n1 + 1), qget(fd1_cyc, nd) + 1);

        // Fairness with all requesters valid
        do_reset();
        n0 = acc0_id.size();
        n1 = acc1_cyc.size();
        req_valid = 4'b1111;
        req_data  = 16'($urandom);
        wait_accepts(n0 + 5, 60);
        req_valid = '0;
        repeat (8) cycle();
        for (int k = 0; k < 5; k++)
            chk($sformatf("fair_order%0d", k), qget(acc0_id, n0 + k), k % NR);
        for (int k = 0; k < 4; k++)
            chk($sformatf("fair_period%0d", k),
                qget(acc0_cyc, n0 + k + 1) - qget(acc0_cyc, n0 + k), FL + 1 + 1);
        chk("nogap_period", qget(acc1_cyc, n1 + 1) - qget(acc1_cyc, n1), FL + 1);

        // Reset in the middle of a frame of 4'hF
        do_reset();
        nf = frames.size();
        req_valid = 4'b0001;
        req_data  = '0;
        req_data[0 +: W] = 4'hF;
        cycle();
        req_valid = '0;
        cycle();
        cycle();
        reset = 1'b0;
        model_reset();
        #1 chk("rst_so", so_o[0], 1'b0);
        chk("rst_so_valid", sv_o[0], 1'b0);
        req_valid = 4'b1111;
        cycle();
        reset = 1'b1;
        n0 = acc0_id.size();
        wait_accepts(n0 + 1, 10);
        chk("rst_regrant", qget(acc0_id, n0), 0);
        chk("rst_no_done", frames.size(), nf);
        req_valid = '0;
        repeat (10) cycle();

        // Word 4'b0111 (parity bit 1 when enabled)
        nf = frames.size();
        req_valid = 4'b0001;
        req_data  = '0;
        req_data[0 +: W] = 4'b0111;
        cycle();
        req_valid = '0;
        repeat (8) cycle();
        chk("frame_0111", qget(frames, nf), exp_frame(4'b0111));

        // Random traffic with occasional resets
        repeat (600) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = NR'($urandom);
                req_data  = 16'($urandom);
            end
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 79) == 0) begin
                reset = 1'b0;
                model_reset();
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
